// File: rtl/sdf_pkg.sv
// sdf_pkg: shared state encoding, parameter defaults and a width helper for
// the radix-2 SDF stage controller.
package sdf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } sdf_state_e;

    localparam int SDF_DELAY_DEF = 16;
    localparam int SDF_TW_AW_DEF = 4;

    // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/sdf_stage_ctrl_if.sv
// sdf_stage_ctrl_if: sample handshake in, datapath controls and status out.
// master = sample source / observer, slave = the stage controller.
interface sdf_stage_ctrl_if
    import sdf_pkg::*;
#(
    parameter int TW_AW = SDF_TW_AW_DEF
) ();

    logic             in_valid;
    logic             in_last;
    logic             bf_en;
    logic             dl_shift;
    logic             tw_en;
    logic [TW_AW-1:0] tw_addr;
    logic             out_valid;
    logic             out_first;
    logic             busy;
    logic [1:0]       state;
    logic             err;

    modport master (
        output in_valid, in_last,
        input  bf_en, dl_shift, tw_en, tw_addr, out_valid, out_first, busy, state, err
    );

    modport slave (
        input  in_valid, in_last,
        output bf_en, dl_shift, tw_en, tw_addr, out_valid, out_first, busy, state, err
    );

endinterface

// File: rtl/sdf_phase_cnt.sv
// sdf_phase_cnt: modulo-2*DELAY sample counter of the SDF stage.
// phase = counter MSB (0 = fill half, 1 = butterfly half), idx = position
// within the half, idx_last = idx at DELAY-1, wrap = counter at 2*DELAY-1.
module sdf_phase_cnt
    import sdf_pkg::*;
#(
    parameter  int DELAY = SDF_DELAY_DEF,
    localparam int IW    = (DELAY > 1) ? clog2(DELAY) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic          clr,
    output logic          phase,
    output logic [IW-1:0] idx,
    output logic          idx_last,
    output logic          wrap
);

    localparam int CW = clog2(2 * DELAY);

    logic [CW-1:0] cnt;

    // Count accepted advances; clear wins, and the power-of-two range wraps by itself.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign phase = cnt[CW-1];

    generate
        if (DELAY > 1) begin : g_idx
            assign idx = cnt[IW-1:0];
        end else begin : g_idx_one
            assign idx = '0;
        end
    endgenerate

    assign idx_last = (idx == IW'(DELAY - 1));
    assign wrap     = phase & idx_last;

endmodule

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: control FSM for one radix-2 single-path delay-feedback stage.
// Drives the delay-line shift, butterfly select and twiddle lookup in the same
// cycle as the sample, and flags the registered stage output.
// Optional feature: define SDF_CTRL_FLUSH_EN to drain the last block on in_last
// (FLUSH state, sticky protocol error); otherwise the stage streams until reset.
module sdf_stage_ctrl
    import sdf_pkg::*;
#(
    parameter int DELAY = SDF_DELAY_DEF,
    parameter int TW_AW = SDF_TW_AW_DEF
) (
    input logic              clk,
    input logic              rst_n,
    sdf_stage_ctrl_if.slave  bus
);

    localparam int IW    = (DELAY > 1) ? clog2(DELAY) : 1;
    localparam int TW_SH = TW_AW - clog2(DELAY);

    sdf_state_e       st;
    logic             first_pend;
    logic             out_valid_q;
    logic             out_first_q;
    logic             adv;
    logic             clr;
    logic             phase;
    logic             idx_last;
    logic [IW-1:0]    idx;
    logic             run_or_flush;
    logic             tw_en_c;
    logic [TW_AW-1:0] tw_addr_c;

`ifdef SDF_CTRL_FLUSH_EN
    logic wrap;
    logic err_q;

    // FLUSH advances on its own and restarts the counter after its last step.
    assign adv = (st == ST_FLUSH) ? 1'b1 : bus.in_valid;
    assign clr = (st == ST_FLUSH) && idx_last;
`else
    // Without FLUSH nothing consumes the block-end flag.
    logic wrap_unused;

    assign adv = bus.in_valid;
    assign clr = 1'b0;
`endif

    sdf_phase_cnt #(
        .DELAY (DELAY)
    ) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (adv),
        .clr      (clr),
        .phase    (phase),
        .idx      (idx),
        .idx_last (idx_last),
`ifdef SDF_CTRL_FLUSH_EN
        .wrap     (wrap)
`else
        .wrap     (wrap_unused)
`endif
    );

    assign run_or_flush = (st == ST_RUN) || (st == ST_FLUSH);

    // Twiddle lookup: only the fill half of a block after the first one is rotated.
    always_comb begin
        // NOTE: defaults first, so no path through this block can infer a latch.
        tw_en_c   = 1'b0;
        tw_addr_c = '0;
        if (adv && !phase && run_or_flush) begin
            tw_en_c   = 1'b1;
            tw_addr_c = TW_AW'(idx) << TW_SH;
        end
    end

    // Control FSM with registered output-valid, first-output and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: asynchronous reset abandons the frame at once; outputs follow combinationally.
        if (!rst_n) begin
            st          <= ST_IDLE;
            first_pend  <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
`ifdef SDF_CTRL_FLUSH_EN
            err_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= adv && run_or_flush;
            out_first_q <= adv && (st == ST_RUN) && first_pend;

            case (st)
                ST_IDLE, ST_FILL: begin
                    if (bus.in_valid) begin
                        if (idx_last && !phase) begin
                            st         <= ST_RUN;
                            first_pend <= 1'b1;
                        end else begin
                            st <= ST_FILL;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.in_valid) begin
                        first_pend <= 1'b0;
`ifdef SDF_CTRL_FLUSH_EN
                        if (bus.in_last && wrap) begin
                            st <= ST_FLUSH;
                        end
`endif
                    end
                end
`ifdef SDF_CTRL_FLUSH_EN
                ST_FLUSH: begin
                    if (idx_last) begin
                        st <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    st <= ST_IDLE;
                end
            endcase

`ifdef SDF_CTRL_FLUSH_EN
            // Misplaced frame end, or a sample offered while draining, is sticky.
            if ((bus.in_valid && st == ST_FLUSH) ||
                (bus.in_valid && bus.in_last && st != ST_FLUSH && !wrap)) begin
                err_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.dl_shift  = adv;
    assign bus.bf_en     = adv & phase;
    assign bus.tw_en     = tw_en_c;
    assign bus.tw_addr   = tw_addr_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.busy      = (st != ST_IDLE);
    assign bus.state     = st;
`ifdef SDF_CTRL_FLUSH_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb_sdf_stage_ctrl: scoreboard bench for sdf_stage_ctrl (DELAY=16, plus a
// DELAY=8 instance for twiddle stepping and fill length). Works with and
// without SDF_CTRL_FLUSH_EN.
module tb_sdf_stage_ctrl;
    import sdf_pkg::*;

    localparam int D  = 16;
    localparam int D8 = 8;
    localparam int AW = 4;

`ifdef SDF_CTRL_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdf_stage_ctrl_if #(.TW_AW(AW)) bus ();
    sdf_stage_ctrl_if #(.TW_AW(AW)) bus8 ();

    sdf_stage_ctrl #(.DELAY(D), .TW_AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    sdf_stage_ctrl #(.DELAY(D8), .TW_AW(AW)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position counted in accepted samples.
    typedef struct {
        int stamp;
        bit first;
    } exp_t;

    exp_t q[$];
    int   m_pos = 0;
    bit   m_active = 0;
    int   m_flush = 0;
    bit   m_err = 0;
    bit   m_first_pend = 0;
    int   n_out = 0;
    int   n_first = 0;
    int   n_bf = 0;

    function automatic int m_state();
        if (!m_active) return 0;
        if (m_flush > 0) return 3;
        if (m_pos < D) return 1;
        return 2;
    endfunction

    // Monitor: every presented output must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("out_valid_unexpected", bus.out_valid, 0);
                end else begin
                    e = q.pop_front();
                    check("out_cycle", cyc, e.stamp);
                    check("out_first", bus.out_first, e.first);
                    n_out++;
                    if (bus.out_first === 1'b1) n_first++;
                end
            end else begin
                if (q.size() > 0 && q[0].stamp <= cyc) begin
                    e = q.pop_front();
                    check("out_valid_missing", bus.out_valid, 1);
                end else begin
                    check("out_first_idle", bus.out_first, 0);
                end
            end
        end
    end

    // One cycle of stimulus on the DELAY=16 instance, checked against the model.
    task automatic step(input bit iv, input bit il);
        int   st;
        int   k;
        int   idx;
        bit   adv;
        bit   ph;
        bit   twe;
        exp_t e;
        @(negedge clk);
        st = m_state();
        check("state", bus.state, st);
        check("busy", bus.busy, st != 0);
        check("err", bus.err, m_err);
        bus.in_valid = iv;
        bus.in_last  = il;
        #1;
        adv = (st == 3) ? 1'b1 : iv;
        k   = m_pos % (2 * D);
        ph  = (k >= D);
        idx = k % D;
        twe = adv && !ph && (st >= 2);
        check("dl_shift", bus.dl_shift, adv);
        check("bf_en", bus.bf_en, adv && ph);
        check("tw_en", bus.tw_en, twe);
        check("tw_addr", bus.tw_addr, twe ? idx * ((1 << AW) / D) : 0);
        if (bus.bf_en === 1'b1) n_bf++;
        if (adv && st >= 2) begin
            e.stamp = cyc + 1;
            e.first = (st == 2) && m_first_pend;
            q.push_back(e);
            if (st == 2) m_first_pend = 0;
        end
        if (st == 3) begin
            if (iv) m_err = 1;
            m_pos++;
            m_flush--;
            if (m_flush == 0) begin
                m_active = 0;
                m_pos    = 0;
            end
        end else if (iv) begin
            if (FLUSH_EN && il) begin
                if (st == 2 && k == 2 * D - 1) m_flush = D;
                else m_err = 1;
            end
            m_pos++;
            m_active = 1;
            if (m_pos == D) m_first_pend = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.in_last  = 1'b0;
        #1;
        check("rst_state", bus.state, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_first", bus.out_first, 0);
        check("rst_bf_en", bus.bf_en, 0);
        check("rst_dl_shift", bus.dl_shift, 0);
        check("rst_tw_en", bus.tw_en, 0);
        check("rst_tw_addr", bus.tw_addr, 0);
        q.delete();
        m_pos = 0;
        m_active = 0;
        m_flush = 0;
        m_err = 0;
        m_first_pend = 0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // DELAY=8 instance: fill lasts 8 samples, twiddle address steps by 2.
    task automatic run_d8();
        for (int i = 1; i <= 3 * D8; i++) begin
            @(negedge clk);
            check("d8_state", bus8.state, (i == 1) ? 0 : ((i <= D8) ? 1 : 2));
            bus8.in_valid = 1'b1;
            #1;
            if (i <= D8) check("d8_tw_en_fill", bus8.tw_en, 0);
            if (i > 2 * D8) begin
                check("d8_tw_en", bus8.tw_en, 1);
                check("d8_tw_addr", bus8.tw_addr, (i - 2 * D8 - 1) * 2);
            end
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit il;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.in_last  = 1'b0;

        do_reset();
        run_d8();

        // 32 back-to-back samples, frame end on the 32nd, then idle.
        do_reset();
        n_out = 0;
        n_first = 0;
        n_bf = 0;
        for (int i = 1; i <= 2 * D; i++) step(1'b1, i == 2 * D);
        check("bf_en_count", n_bf, D);
        repeat (D + 4) step(1'b0, 1'b0);
        check("out_first_count", n_first, 1);
`ifdef SDF_CTRL_FLUSH_EN
        check("out_valid_count", n_out, 2 * D);
        check("idle_after_flush", bus.state, 0);
`else
        check("out_valid_count", n_out, D);
        check("run_persists", bus.state, 2);
`endif

        // Three-cycle bubble at sample 20.
        do_reset();
        for (int i = 1; i <= 19; i++) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        for (int i = 20; i <= 2 * D; i++) step(1'b1, i == 2 * D);
        repeat (D + 2) step(1'b0, 1'b0);

        // Frame end offered early, at sample 10.
        do_reset();
        for (int i = 1; i <= 2 * D; i++) step(1'b1, (i == 10) || (i == 2 * D));
        repeat (D + 2) step(1'b0, 1'b0);

        // Samples offered while draining.
        do_reset();
        for (int i = 1; i <= 2 * D; i++) step(1'b1, i == 2 * D);
        for (int i = 0; i < D; i++) step(i % 3 == 0, 1'b0);
        repeat (4) step(1'b0, 1'b0);

        // Reset in the middle of a frame, at sample 25.
        do_reset();
        for (int i = 1; i <= 24; i++) step(1'b1, 1'b0);
        do_reset();
        repeat (4) step(1'b0, 1'b0);

        // Randomised streaming with bubbles and frame ends.
        do_reset();
        for (int n = 0; n < 700; n++) begin
            if (m_state() == 2 && (m_pos % (2 * D)) == 2 * D - 1 && $urandom_range(1, 0) == 1)
                il = 1'b1;
            else
                il = ($urandom_range(63, 0) == 0);
            step($urandom_range(3, 0) != 0, il);
        end
        repeat (D + 4) step(1'b0, 1'b0);
        check("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdf_stage_ctrl.md
SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 SHALL have parameter DELAY, default 16, delay-line length of the controlled radix-2 SDF stage (power of 2, 1..16).
REQ-002 SHALL have parameter TW_AW, default 4, twiddle ROM address width; DELAY <= 2**TW_AW.
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input sample present this cycle.
REQ-006 SHALL have port in_last  input  1  sample is the last of the frame; qualified by in_valid.
REQ-007 SHALL have port bf_en  output  1  1 = butterfly phase, 0 = fill/pass phase.
REQ-008 SHALL have port dl_shift  output  1  delay line advances this cycle.
REQ-009 SHALL have port tw_en  output  1  multiply stage output by twiddle.
REQ-010 SHALL have port tw_addr  output  TW_AW  twiddle ROM address.
REQ-011 SHALL have port out_valid  output  1  stage output register holds a valid sample.
REQ-012 SHALL have port out_first  output  1  first valid output of a frame.
REQ-013 SHALL have port busy  output  1  high in FILL, RUN, FLUSH.
REQ-014 SHALL have port state  output  2  FSM state: IDLE=0, FILL=1, RUN=2, FLUSH=3.
REQ-015 SHALL have port err  output  1  sticky protocol error.

Function
REQ-016 SHALL keep counter cnt, width log2(2*DELAY); phase = cnt MSB; idx = cnt low log2(DELAY) bits.
REQ-017 SHALL define adv = in_valid in IDLE/FILL/RUN, adv = 1 in FLUSH; cnt increments on adv, wraps 2*DELAY-1 -> 0.
REQ-018 SHALL drive dl_shift = adv and bf_en = adv & phase, combinationally from current cnt/state/in_valid (same-cycle datapath control).
REQ-019 SHALL drive tw_en = 1 and tw_addr = idx << (TW_AW - log2(DELAY)) when adv & phase==0 & state in {RUN, FLUSH}; else tw_en = 0, tw_addr = 0.
REQ-020 SHALL transition IDLE -> FILL on in_valid (sample counted, cnt 0 -> 1).
REQ-021 SHALL transition FILL -> RUN on the adv that wraps phase 0 -> 1 boundary (cnt DELAY-1 -> DELAY); no output in IDLE/FILL.
REQ-022 SHALL in RUN produce out_valid = 1 one cycle after every adv (registered); out_first = 1 on the first such out_valid after FILL only.
REQ-023 SHALL transition RUN -> FLUSH when in_valid & in_last at cnt = 2*DELAY-1; cnt wraps to 0.
REQ-024 SHALL in FLUSH advance DELAY cycles unconditionally (out_valid each), then -> IDLE with cnt = 0.
REQ-025 SHALL set err when in_last is accepted at cnt != 2*DELAY-1 (FSM unaffected) or in_valid is high in FLUSH (sample dropped).
REQ-026 SHALL continue RUN across block boundaries without gap when in_last is absent (back-to-back streaming).
REQ-027 SHALL hold cnt, state and all controls when in_valid is low in FILL/RUN (bubble); out_valid = 0 the next cycle.

Reset
REQ-028 SHALL on rst_n low asynchronously force state=IDLE, cnt=0, out_valid=0, out_first=0, err=0; combinational outputs then evaluate to bf_en=0, dl_shift=0, tw_en=0, tw_addr=0, busy=0.
REQ-029 SHALL abandon any frame in progress on reset, with no trailing outputs after release.

Configuration
REQ-030 SHALL with SDF_CTRL_FLUSH_EN defined implement FLUSH per REQ-023..REQ-025.
REQ-031 SHALL without SDF_CTRL_FLUSH_EN omit FLUSH: in_last ignored, RUN persists until reset, state 3 unreachable, err tied 0.

Structure
REQ-032 SHALL take state encodings, DELAY/TW_AW defaults and a clog2 helper from shared package sdf_pkg.
REQ-033 SHALL instantiate one sub-module sdf_phase_cnt (cnt register, adv input, phase/idx/wrap outputs).

Verification (DELAY=16, TW_AW=4)
REQ-034 SHALL check 32 back-to-back valid samples, in_last on 32nd: bf_en=1 samples 17..32, out_valid 17 cycles after first sample for 32 cycles, out_first once, state IDLE after 48 cycles.
REQ-035 SHALL check tw_addr = 0..15 with tw_en=1 during the 16 FLUSH cycles, and tw_en=0 throughout FILL.
REQ-036 SHALL check in_valid low 3 cycles at sample 20: cnt, tw_addr, bf_en held; 3 out_valid bubbles.
REQ-037 SHALL check in_last at sample 10: err=1, FSM stays FILL; and in_valid during FLUSH: err=1, FLUSH length unchanged.
REQ-038 SHALL check rst_n low at sample 25: all outputs 0 immediately; state 0 after release.
REQ-039 SHALL check DELAY=8 build: tw_addr steps 0,2,4..14; FILL lasts 8 samples.
